fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/common_pkg.sv | 43 ++++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared types for the core front end: scalar aliases, instruction-bus
// request/response records, the fetch-to-decode record and the fetch FSM
// state encoding.
package common;

  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  // Address of the first instruction fetched after reset.
  localparam u64 PC_INIT = 64'h8000_0000;

  // Request from fetch to the instruction bus. The bus holds a request
  // until it answers with data_ok.
  typedef struct packed {
    u1  valid;
    u64 addr;
  } ibus_req_t;

  // Response from the instruction bus.
  typedef struct packed {
    u1  addr_ok;
    u1  data_ok;
    u32 data;
  } ibus_resp_t;

  // Record handed from fetch to decode.
  typedef struct packed {
    u32 raw_instr;
    u64 pc;
    u1  is_bubble;
  } fetch_data_t;

  // REQ     : a request to pc is outstanding on the bus
  // VALID   : an instruction is buffered and presented downstream
  // DISCARD : the outstanding request belongs to a squashed path
  typedef enum logic [1:0] {
    REQ     = 2'd0,
    VALID   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Issues one bus request at a time, buffers the
// returned instruction for decode, and handles redirects from execute,
// including redirects that arrive while a request is still in flight.
module fetch_stage
  import common::*;
#(
  parameter u64 PC_INIT = common::PC_INIT
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output fetch_data_t dataF,
  output logic        fetch_valid
);

  fetch_state_t state;
  fetch_state_t stateNext;

  u64   pc;
  u64   pcNext;
  u64   pendPc;
  u64   pendPcNext;
  u32   bufInstr;
  u64   bufPc;
  logic bufLoad;

  // addr_ok carries no sequencing meaning here: the bus keeps a request
  // alive until data_ok, so only data_ok advances the FSM.
  logic unusedAddrOk;
  assign unusedAddrOk = iresp.addr_ok;

  // State register.
  // NOTE: synchronous reset inside the clocked block, and every register
  // written with <= so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state, next-pc, redirect bookkeeping and buffer-load decision.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    stateNext  = state;
    pcNext     = pc;
    pendPcNext = pendPc;
    bufLoad    = 1'b0;

    unique case (state)
      REQ: begin
        if (iresp.data_ok) begin
          if (redirect_valid) begin
            // Data belongs to the wrong path; refetch from the target.
            pcNext = redirect_pc;
          end else begin
            bufLoad   = 1'b1;
            stateNext = VALID;
          end
        end else if (redirect_valid) begin
          // Request cannot be withdrawn: remember the target and drop
          // whatever the bus eventually returns.
          pendPcNext = redirect_pc;
          stateNext  = DISCARD;
        end
      end

      DISCARD: begin
        // A later redirect supersedes an earlier one.
        if (redirect_valid) begin
          pendPcNext = redirect_pc;
        end
        if (iresp.data_ok) begin
          pcNext    = redirect_valid ? redirect_pc : pendPc;
          stateNext = REQ;
        end
      end

      VALID: begin
        // Redirect wins over stall: the buffered instruction is squashed.
        if (redirect_valid) begin
          pcNext    = redirect_pc;
          stateNext = REQ;
        end else if (!stall) begin
          pcNext    = bufPc + 64'd4;
          stateNext = REQ;
        end
      end

      default: begin
        stateNext = REQ;
      end
    endcase
  end

  // Fetch address, pending redirect target and instruction buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= PC_INIT;
      pendPc   <= '0;
      bufInstr <= '0;
      bufPc    <= '0;
    end else begin
      pc     <= pcNext;
      pendPc <= pendPcNext;
      if (bufLoad) begin
        bufInstr <= iresp.data;
        bufPc    <= pc;
      end
    end
  end

  // Bus request and decode-side outputs; reset forces the idle view even
  // before the first reset edge has settled the state register.
  always_comb begin
    ireq.valid      = !reset && (state != VALID);
    ireq.addr       = pc;
    fetch_valid     = !reset && (state == VALID);
    dataF.raw_instr = bufInstr;
    dataF.pc        = bufPc;
    dataF.is_bubble = reset || (state != VALID);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios for reset, first fetch,
// stall, redirects in every state and pc wrap, then a randomized run
// compared cycle by cycle against a transaction-level model of the stage.
module tb_fetch_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  fetch_data_t dataF;
  logic        fetch_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.PC_INIT(64'h8000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dataF          (dataF),
    .fetch_valid    (fetch_valid)
  );

  // Reference model: what the stage is doing in architectural terms.
  //   mHolding  : an instruction is being presented to decode
  //   mSquashed : the request in flight belongs to a squashed path
  //   mFetchPc  : address of the request in flight
  //   mTarget   : where fetch resumes once a squashed request returns
  //   mShownPc / mShownInstr : last instruction handed to decode
  bit mHolding;
  bit mSquashed;
  u64 mFetchPc;
  u64 mTarget;
  u64 mShownPc;
  u32 mShownInstr;

  task automatic model_step();
    if (reset) begin
      mHolding    = 0;
      mSquashed   = 0;
      mFetchPc    = 64'h8000_0000;
      mTarget     = 64'h0;
      mShownPc    = 64'h0;
      mShownInstr = 32'h0;
    end else if (mHolding) begin
      if (redirect_valid) begin
        mHolding = 0;
        mFetchPc = redirect_pc;
      end else if (!stall) begin
        mHolding = 0;
        mFetchPc = mShownPc + 64'd4;
      end
    end else if (mSquashed) begin
      if (redirect_valid) mTarget = redirect_pc;
      if (iresp.data_ok) begin
        mSquashed = 0;
        mFetchPc  = mTarget;
      end
    end else if (iresp.data_ok) begin
      if (redirect_valid) begin
        mFetchPc = redirect_pc;
      end else begin
        mHolding    = 1;
        mShownPc    = mFetchPc;
        mShownInstr = iresp.data;
      end
    end else if (redirect_valid) begin
      mSquashed = 1;
      mTarget   = redirect_pc;
    end
  endtask

  // Drive inputs for the current cycle and let combinational outputs settle.
  task automatic apply(input logic r, input logic dok, input u32 data,
                       input logic st, input logic rv, input u64 rpc);
    reset          = r;
    iresp.addr_ok  = 1'($urandom_range(0, 1));
    iresp.data_ok  = dok;
    iresp.data     = data;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  // Clock edge: DUT and model both consume the inputs of this cycle.
  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 32'h0, 0, 0, 64'h0);
  endtask

  task automatic test_reset();
    apply(1, 0, 32'h0, 0, 0, 64'h0);
    advance();
    apply(1, 0, 32'h0, 0, 0, 64'h0);
    advance();
    apply(1, 0, 32'h0, 0, 0, 64'h0);
    checks++;
    if ({ireq.valid, fetch_valid, dataF.is_bubble} !== 3'b001) begin
      errors++;
      $display("FAIL reset_flags: got valid/fv/bubble=%b expected 001",
               {ireq.valid, fetch_valid, dataF.is_bubble});
    end
    checks++;
    if (dataF.raw_instr !== 32'h0 || dataF.pc !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got raw=%h pc=%h expected 0/0", dataF.raw_instr, dataF.pc);
    end
  endtask

  task automatic test_first_fetch();
    idle();
    checks++;
    if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL first_req: got valid=%b addr=%h expected 1/80000000", ireq.valid, ireq.addr);
    end
    advance();
    apply(0, 1, 32'h0000_0013, 0, 0, 64'h0);
    checks++;
    if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL first_req_held: got valid=%b addr=%h expected 1/80000000", ireq.valid, ireq.addr);
    end
    advance();
    idle();
    checks++;
    if ({fetch_valid, dataF.is_bubble, ireq.valid} !== 3'b100 ||
        dataF.pc !== 64'h8000_0000 || dataF.raw_instr !== 32'h0000_0013) begin
      errors++;
      $display("FAIL first_deliver: got fv/bub/rv=%b pc=%h raw=%h expected 100/80000000/00000013",
               {fetch_valid, dataF.is_bubble, ireq.valid}, dataF.pc, dataF.raw_instr);
    end
    advance();
    idle();
    checks++;
    if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0004 || fetch_valid !== 1'b0 ||
        dataF.raw_instr !== 32'h0000_0013) begin
      errors++;
      $display("FAIL second_req: got valid=%b addr=%h fv=%b raw=%h expected 1/80000004/0/00000013",
               ireq.valid, ireq.addr, fetch_valid, dataF.raw_instr);
    end
  endtask

  task automatic test_stall();
    apply(0, 1, 32'h0000_0093, 0, 0, 64'h0);
    advance();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 32'h0, 1, 0, 64'h0);
      checks++;
      if ({fetch_valid, ireq.valid} !== 2'b10 || dataF.pc !== 64'h8000_0004 ||
          dataF.raw_instr !== 32'h0000_0093) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got fv/rv=%b pc=%h raw=%h expected 10/80000004/00000093",
                 i, {fetch_valid, ireq.valid}, dataF.pc, dataF.raw_instr);
      end
      advance();
    end
    idle();
    checks++;
    if (fetch_valid !== 1'b1 || ireq.valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got fv=%b rv=%b expected 1/0", fetch_valid, ireq.valid);
    end
    advance();
    idle();
    checks++;
    if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0008) begin
      errors++;
      $display("FAIL stall_next_req: got valid=%b addr=%h expected 1/80000008", ireq.valid, ireq.addr);
    end
  endtask

  task automatic test_redirect_pending();
    apply(0, 0, 32'h0, 0, 1, 64'h8000_1000);
    advance();
    idle();
    checks++;
    if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0008) begin
      errors++;
      $display("FAIL discard_addr_held: got valid=%b addr=%h expected 1/80000008", ireq.valid, ireq.addr);
    end
    advance();
    apply(0, 1, 32'hDEAD_BEEF, 0, 0, 64'h0);
    advance();
    idle();
    checks++;
    if (fetch_valid !== 1'b0 || ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_1000 ||
        dataF.raw_instr !== 32'h0000_0093) begin
      errors++;
      $display("FAIL redirect_pending: got fv=%b valid=%b addr=%h raw=%h expected 0/1/80001000/00000093",
               fetch_valid, ireq.valid, ireq.addr, dataF.raw_instr);
    end
  endtask

  task automatic test_discard_multi();
    apply(0, 0, 32'h0, 0, 1, 64'h8000_2000);
    advance();
    idle();
    advance();
    apply(0, 0, 32'h0, 0, 1, 64'h8000_3000);
    checks++;
    if (ireq.addr !== 64'h8000_1000) begin
      errors++;
      $display("FAIL discard_multi_hold: got addr=%h expected 80001000", ireq.addr);
    end
    advance();
    apply(0, 1, 32'hBAD0_0001, 0, 1, 64'h8000_4000);
    advance();
    idle();
    checks++;
    if (fetch_valid !== 1'b0 || ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_4000) begin
      errors++;
      $display("FAIL discard_last_wins: got fv=%b valid=%b addr=%h expected 0/1/80004000",
               fetch_valid, ireq.valid, ireq.addr);
    end
  endtask

  task automatic test_redirect_stall();
    apply(0, 1, 32'h0010_0073, 0, 0, 64'h0);
    advance();
    apply(0, 0, 32'h0, 1, 1, 64'h8000_5000);
    checks++;
    if (fetch_valid !== 1'b1 || dataF.pc !== 64'h8000_4000) begin
      errors++;
      $display("FAIL redir_stall_pre: got fv=%b pc=%h expected 1/80004000", fetch_valid, dataF.pc);
    end
    advance();
    idle();
    checks++;
    if ({fetch_valid, dataF.is_bubble, ireq.valid} !== 3'b011 || ireq.addr !== 64'h8000_5000 ||
        dataF.raw_instr !== 32'h0010_0073) begin
      errors++;
      $display("FAIL redir_stall: got fv/bub/rv=%b addr=%h raw=%h expected 011/80005000/00100073",
               {fetch_valid, dataF.is_bubble, ireq.valid}, ireq.addr, dataF.raw_instr);
    end
  endtask

  task automatic test_wrap();
    apply(0, 1, 32'h5555_5555, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    advance();
    idle();
    checks++;
    if (ireq.valid !== 1'b1 || ireq.addr !== 64'hFFFF_FFFF_FFFF_FFFC || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_on_dataok: got valid=%b addr=%h fv=%b expected 1/fffffffffffffffc/0",
               ireq.valid, ireq.addr, fetch_valid);
    end
    apply(0, 1, 32'h0000_1234, 0, 0, 64'h0);
    advance();
    idle();
    advance();
    idle();
    checks++;
    if (ireq.valid !== 1'b1 || ireq.addr !== 64'h0) begin
      errors++;
      $display("FAIL pc_wrap: got valid=%b addr=%h expected 1/0", ireq.valid, ireq.addr);
    end
  endtask

  task automatic test_reset_mid();
    // Reset while an instruction is presented.
    apply(0, 1, 32'h0000_0abc, 0, 0, 64'h0);
    advance();
    apply(1, 0, 32'h0, 0, 0, 64'h0);
    advance();
    apply(1, 0, 32'h0, 0, 0, 64'h0);
    checks++;
    if ({ireq.valid, fetch_valid, dataF.is_bubble} !== 3'b001 ||
        dataF.raw_instr !== 32'h0 || dataF.pc !== 64'h0) begin
      errors++;
      $display("FAIL reset_in_valid: got flags=%b raw=%h pc=%h expected 001/0/0",
               {ireq.valid, fetch_valid, dataF.is_bubble}, dataF.raw_instr, dataF.pc);
    end
    advance();
    idle();
    checks++;
    if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL resume_after_valid: got valid=%b addr=%h expected 1/80000000", ireq.valid, ireq.addr);
    end
    // Reset while a squashed request is in flight.
    apply(0, 0, 32'h0, 0, 1, 64'h9000_0000);
    advance();
    apply(1, 1, 32'hFFFF_FFFF, 0, 0, 64'h0);
    advance();
    apply(1, 0, 32'h0, 0, 0, 64'h0);
    checks++;
    if ({ireq.valid, fetch_valid, dataF.is_bubble} !== 3'b001 ||
        dataF.raw_instr !== 32'h0 || dataF.pc !== 64'h0) begin
      errors++;
      $display("FAIL reset_in_discard: got flags=%b raw=%h pc=%h expected 001/0/0",
               {ireq.valid, fetch_valid, dataF.is_bubble}, dataF.raw_instr, dataF.pc);
    end
    advance();
    apply(0, 1, 32'h0000_0777, 0, 0, 64'h0);
    checks++;
    if (ireq.valid !== 1'b1 || ireq.addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL resume_after_discard: got valid=%b addr=%h expected 1/80000000", ireq.valid, ireq.addr);
    end
    advance();
    idle();
    checks++;
    if (fetch_valid !== 1'b1 || dataF.pc !== 64'h8000_0000 || dataF.raw_instr !== 32'h0000_0777) begin
      errors++;
      $display("FAIL resume_deliver: got fv=%b pc=%h raw=%h expected 1/80000000/00000777",
               fetch_valid, dataF.pc, dataF.raw_instr);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic r, dok, st, rv;
      u64   rpc;
      r   = ($urandom_range(0, 99) == 0);
      dok = !mHolding && ($urandom_range(0, 2) == 0);
      st  = ($urandom_range(0, 1) == 1);
      rv  = ($urandom_range(0, 5) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      apply(r, dok, $urandom, st, rv, rpc);
      checks++;
      if (ireq.valid !== (!reset && !mHolding) ||
          (!reset && !mHolding && ireq.addr !== mFetchPc)) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_ireq @%0d: got valid=%b addr=%h expected %b/%h",
                   cyc, ireq.valid, ireq.addr, !reset && !mHolding, mFetchPc);
      end
      checks++;
      if (fetch_valid !== (!reset && mHolding) || dataF.is_bubble !== (reset || !mHolding) ||
          dataF.pc !== mShownPc || dataF.raw_instr !== mShownInstr) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_dataF @%0d: got fv=%b bub=%b pc=%h raw=%h expected %b/%b/%h/%h",
                   cyc, fetch_valid, dataF.is_bubble, dataF.pc, dataF.raw_instr,
                   !reset && mHolding, reset || !mHolding, mShownPc, mShownInstr);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_pending();
    test_discard_multi();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
